pipe_latch_elastic: RTL and testbench

Parametrised elastic pipeline stage between two pipeline stages. It is a DEPTH-entry in-order buffer with valid/ready handshakes on both sides. The hazard-unit control code keeps its established meaning: 00 normal, 01 squash, 10 stall, 11 stall+bubble. Unlike a single-register latch, it absorbs downstream back-pressure without losing data, and it can hold the upstream side while the downstream side drains.

---
 rtl/pipe_latch_elastic.sv | 90 +++++++++
 tb/tb_pipe_latch_elastic.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_elastic.sv
// Elastic DEPTH-entry in-order stage with hazard control (00 normal, 01 squash, 10 stall, 11 stall+bubble).
// Latency 1 cycle (no bypass); in_ready depends only on count/ctr; full blocks same-cycle refill.
// Optional stall/bubble cycle counter built when PIPE_LATCH_STATS_EN is defined.
module pipe_latch_elastic #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ctr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [15:0]      stall_cycles
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop, squash;

    assign squash    = (ctr == 2'b01);
    assign in_ready  = !rst && (count_q < FULL) && !ctr[1];
    assign out_valid = !rst && (count_q != '0) && (ctr != 2'b10);
    // Empty buffer presents a zero-payload bubble; stall does not mask data.
    assign out_data  = (count_q != '0) ? mem[rp_q] : '0;
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (squash) begin
            count_d = '0;
            rp_d    = wp_q;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !squash) mem[wp_q] <= in_data;
    end

`ifdef PIPE_LATCH_STATS_EN
    logic [15:0] stall_q;

    // Saturating; squash leaves it alone, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (ctr[1] && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Directed self-checking bench for pipe_latch_elastic (WIDTH=32, DEPTH=2).
module tb_pipe_latch_elastic;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    pipe_latch_elastic #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .ctr(ctr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_LATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    initial begin
        rst = 1'b1; ctr = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0; #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_out_data", out_data, 32'd0);
        chk("post_rst_stall", 32'(stall_cycles), 32'd0);

        // Streaming, 1 beat/cycle, 1-cycle latency
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA;
        step();
        chk("strm_a_vld", 32'(out_valid), 32'd1);
        chk("strm_a_dat", out_data, 32'hA);
        chk("strm_a_cnt", 32'(count), 32'd1);
        in_data = 32'hB; step();
        chk("strm_b_dat", out_data, 32'hB);
        chk("strm_b_cnt", 32'(count), 32'd1);
        in_data = 32'hC; step();
        chk("strm_c_dat", out_data, 32'hC);
        chk("strm_c_cnt", 32'(count), 32'd1);
        in_valid = 1'b0; step();
        chk("strm_drain_cnt", 32'(count), 32'd0);
        chk("strm_drain_vld", 32'(out_valid), 32'd0);
        chk("strm_drain_dat", out_data, 32'd0);

        // Back-pressure: fill, reject third beat, drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; step();
        chk("bp_11_cnt", 32'(count), 32'd1);
        in_data = 32'h22; step();
        chk("bp_full_cnt", 32'(count), 32'd2);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        in_data = 32'h55; step();
        chk("bp_reject_cnt", 32'(count), 32'd2);
        chk("bp_reject_head", out_data, 32'h11);
        in_valid = 1'b0; out_ready = 1'b1; #1;
        chk("bp_full_pop_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("bp_pop1_dat", out_data, 32'h22);
        chk("bp_pop1_cnt", 32'(count), 32'd1);
        chk("bp_pop1_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_pop2_cnt", 32'(count), 32'd0);
        chk("bp_pop2_vld", 32'(out_valid), 32'd0);

        // Squash of a full buffer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1; step();
        in_data = 32'h2; step();
        chk("sq_fill_cnt", 32'(count), 32'd2);
        ctr = 2'b01; in_data = 32'h33; step();
        ctr = 2'b00; in_valid = 1'b0; #1;
        chk("sq_cnt", 32'(count), 32'd0);
        chk("sq_vld", 32'(out_valid), 32'd0);
        chk("sq_dat", out_data, 32'd0);
        // Squash while empty: the offered beat is discarded
        ctr = 2'b01; in_valid = 1'b1; in_data = 32'h33; step();
        ctr = 2'b00; in_valid = 1'b0; #1;
        chk("sq_empty_cnt", 32'(count), 32'd0);
        chk("sq_empty_dat", out_data, 32'd0);
        in_valid = 1'b1; in_data = 32'h66; step();
        in_valid = 1'b0;
        chk("sq_after_dat", out_data, 32'h66);
        chk("sq_after_cnt", 32'(count), 32'd1);
        out_ready = 1'b1; step();
        chk("sq_after_drain", 32'(count), 32'd0);

        // Stall: frozen for 3 cycles
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7; step();
        in_data = 32'h8; step();
        ctr = 2'b10; out_ready = 1'b1; in_data = 32'h99; #1;
        chk("st_in_ready", 32'(in_ready), 32'd0);
        chk("st_out_valid", 32'(out_valid), 32'd0);
        step(); step(); step();
        chk("st_cnt", 32'(count), 32'd2);
        chk("st_head", out_data, 32'h7);
        chk("st_stall_cycles", 32'(stall_cycles), STATS ? 32'd3 : 32'd0);

        // Stall+bubble: upstream held, downstream drains
        ctr = 2'b11; #1;
        chk("sb_in_ready", 32'(in_ready), 32'd0);
        chk("sb_out_valid", 32'(out_valid), 32'd1);
        chk("sb_dat0", out_data, 32'h7);
        step();
        chk("sb_dat1", out_data, 32'h8);
        chk("sb_cnt1", 32'(count), 32'd1);
        step();
        chk("sb_cnt2", 32'(count), 32'd0);
        chk("sb_vld2", 32'(out_valid), 32'd0);
        chk("sb_dat2", out_data, 32'd0);
        chk("sb_stall_cycles", 32'(stall_cycles), STATS ? 32'd5 : 32'd0);
        ctr = 2'b00; in_valid = 1'b0;

        // Reset mid-operation drops buffered beat
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44; step();
        chk("mr_push_cnt", 32'(count), 32'd1);
        in_valid = 1'b0; rst = 1'b1; #1;
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        step();
        chk("mr_cnt", 32'(count), 32'd0);
        rst = 1'b0; out_ready = 1'b1; step();
        chk("mr_post_vld", 32'(out_valid), 32'd0);
        chk("mr_post_dat", out_data, 32'd0);
        chk("mr_post_in_ready", 32'(in_ready), 32'd1);
        chk("mr_post_stall", 32'(stall_cycles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
